// File: rtl/mips_dmem_responder_if.sv
// CPU <-> data-memory load/store handshake bundle for mips_dmem_responder.
interface mips_dmem_responder_if;
   logic        req_in;
   logic        writeCntrl_in;
   logic [31:0] address_in;
   logic [31:0] writeData_in;
   logic        ready_out;
   logic        ack_out;
   logic [31:0] data_out;
   logic        busy_out;
   logic        err_out;

   modport master (
      output req_in, writeCntrl_in, address_in, writeData_in,
      input  ready_out, ack_out, data_out, busy_out, err_out
   );

   modport slave (
      input  req_in, writeCntrl_in, address_in, writeData_in,
      output ready_out, ack_out, data_out, busy_out, err_out
   );
endinterface

// File: rtl/mips_dmem_responder.sv
// Slow data-memory responder: one request, fixed wait states, one-cycle ack pulse.
// Optional DMEM_ERR_EN macro enables misalignment / out-of-range error reporting.
module mips_dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned WAIT_STATES = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0
) (
   input logic                  clk,
   input logic                  reset,
   mips_dmem_responder_if.slave dmem
);
   localparam int unsigned IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              wr_q, err_q;
   logic [IdxW-1:0]   idx_q;
   logic [31:0]       wdata_q, data_q;
   logic [31:0]       mem_q [DEPTH_WORDS];

   logic              accept, enter_resp, mem_we;
   logic [31:0]       off;
   logic              acc_err;
   logic              cur_wr, cur_err;
   logic [IdxW-1:0]   cur_idx;
   logic [31:0]       cur_wdata;

   assign accept     = dmem.req_in & (state_q == StIdle);
   assign off        = dmem.address_in - BASE_ADDR;
   assign enter_resp = (state_d == StResp) && (state_q != StResp);

`ifdef DMEM_ERR_EN
   localparam logic [32:0] SpanBytes = 33'(DEPTH_WORDS) << 2;
   // Zero-extended compare also flags addresses below BASE_ADDR (subtract wraps high).
   assign acc_err = (dmem.address_in[1:0] != 2'b00) || ({1'b0, off} >= SpanBytes);
   assign dmem.err_out = err_q & (state_q == StResp);
`else
   logic unused_off;
   assign unused_off   = ^{off[31:IdxW+2], off[1:0]};
   assign acc_err      = 1'b0;
   assign dmem.err_out = 1'b0;
`endif

   // With zero wait states the access edge is also the accept edge, so use live inputs.
   always_comb begin
      if (state_q == StIdle) begin
         cur_wr    = dmem.writeCntrl_in;
         cur_err   = acc_err;
         cur_idx   = off[IdxW+1:2];
         cur_wdata = dmem.writeData_in;
      end else begin
         cur_wr    = wr_q;
         cur_err   = err_q;
         cur_idx   = idx_q;
         cur_wdata = wdata_q;
      end
   end

   assign mem_we = enter_resp & cur_wr & ~cur_err & ~reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         wr_q    <= 1'b0;
         err_q   <= 1'b0;
         idx_q   <= '0;
         wdata_q <= 32'd0;
         data_q  <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            wr_q    <= dmem.writeCntrl_in;
            err_q   <= acc_err;
            idx_q   <= off[IdxW+1:2];
            wdata_q <= dmem.writeData_in;
         end
         if (enter_resp) begin
            if (cur_err)     data_q <= 32'd0;
            else if (cur_wr) data_q <= cur_wdata;
            else             data_q <= mem_q[cur_idx];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem_q[cur_idx] <= cur_wdata;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               cnt_d   = 4'(WAIT_STATES);
               state_d = (WAIT_STATES == 0) ? StResp : StWait;
            end
         end
         StWait: begin
            if (cnt_q <= 4'd1) state_d = StResp;
            else               cnt_d   = cnt_q - 4'd1;
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      dmem.ready_out = 1'b0;
      dmem.busy_out  = 1'b0;
      dmem.ack_out   = 1'b0;
      unique case (state_q)
         StIdle: dmem.ready_out = 1'b1;
         StWait: dmem.busy_out  = 1'b1;
         StResp: begin
            dmem.busy_out = 1'b1;
            dmem.ack_out  = 1'b1;
         end
         default: ;
      endcase
   end

   assign dmem.data_out = data_q;
endmodule

// File: tb/tb_mips_dmem_responder.sv
// Directed self-checking bench: two instances (WAIT_STATES=2 and WAIT_STATES=0).
module tb_mips_dmem_responder;
   logic clk;
   logic reset;
   int   n_tests = 0;
   int   n_fail  = 0;

   mips_dmem_responder_if bus ();
   mips_dmem_responder_if bus0 ();

   mips_dmem_responder #(
      .DEPTH_WORDS(256), .WAIT_STATES(2), .BASE_ADDR(32'h0)
   ) u_dut (
      .clk  (clk),
      .reset(reset),
      .dmem (bus)
   );

   mips_dmem_responder #(
      .DEPTH_WORDS(256), .WAIT_STATES(0), .BASE_ADDR(32'h0)
   ) u_dut0 (
      .clk  (clk),
      .reset(reset),
      .dmem (bus0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Call at a negedge with the WAIT_STATES=2 DUT idle; returns at the negedge of T+4.
   task automatic txn(input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_d, input logic exp_e, input string tag);
      bus.req_in        = 1'b1;
      bus.writeCntrl_in = wr;
      bus.address_in    = a;
      bus.writeData_in  = d;
      chk({tag, ".rdyT"}, 32'(bus.ready_out), 32'd1);
      @(negedge clk);
      bus.req_in        = 1'b0;
      bus.writeCntrl_in = ~wr;
      bus.address_in    = 32'hFFFF_FFFC;
      bus.writeData_in  = 32'h0;
      chk({tag, ".rdyT1"}, 32'(bus.ready_out), 32'd0);
      chk({tag, ".ackT1"}, 32'(bus.ack_out), 32'd0);
      @(negedge clk);
      chk({tag, ".ackT2"}, 32'(bus.ack_out), 32'd0);
      chk({tag, ".busyT2"}, 32'(bus.busy_out), 32'd1);
      @(negedge clk);
      chk({tag, ".ackT3"}, 32'(bus.ack_out), 32'd1);
      chk({tag, ".rdyT3"}, 32'(bus.ready_out), 32'd0);
      chk({tag, ".data"}, bus.data_out, exp_d);
      chk({tag, ".err"}, 32'(bus.err_out), 32'(exp_e));
      @(negedge clk);
      chk({tag, ".rdyT4"}, 32'(bus.ready_out), 32'd1);
      chk({tag, ".ackT4"}, 32'(bus.ack_out), 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      bus.req_in = 1'b0;  bus.writeCntrl_in = 1'b0;
      bus.address_in = 32'h0;  bus.writeData_in = 32'h0;
      bus0.req_in = 1'b0; bus0.writeCntrl_in = 1'b0;
      bus0.address_in = 32'h0; bus0.writeData_in = 32'h0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst.ready", 32'(bus.ready_out), 32'd1);
      chk("rst.ack", 32'(bus.ack_out), 32'd0);
      chk("rst.data", bus.data_out, 32'd0);
      chk("rst.busy", 32'(bus.busy_out), 32'd0);
      chk("rst.err", 32'(bus.err_out), 32'd0);
      chk("rst0.ready", 32'(bus0.ready_out), 32'd1);

      txn(1'b1, 32'h10, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, "t1w");
      txn(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "t1r");

      // Zero wait states: ack in T+1, ready again in T+2.
      bus0.req_in = 1'b1; bus0.writeCntrl_in = 1'b1;
      bus0.address_in = 32'h8; bus0.writeData_in = 32'h55;
      chk("t2w.rdyT", 32'(bus0.ready_out), 32'd1);
      @(negedge clk);
      bus0.req_in = 1'b0;
      chk("t2w.ackT1", 32'(bus0.ack_out), 32'd1);
      chk("t2w.rdyT1", 32'(bus0.ready_out), 32'd0);
      chk("t2w.data", bus0.data_out, 32'h55);
      @(negedge clk);
      chk("t2w.rdyT2", 32'(bus0.ready_out), 32'd1);
      chk("t2w.ackT2", 32'(bus0.ack_out), 32'd0);
      bus0.req_in = 1'b1; bus0.writeCntrl_in = 1'b0;
      @(negedge clk);
      bus0.req_in = 1'b0;
      chk("t2r.ackT1", 32'(bus0.ack_out), 32'd1);
      chk("t2r.data", bus0.data_out, 32'h55);
      @(negedge clk);
      chk("t2r.rdyT2", 32'(bus0.ready_out), 32'd1);

      txn(1'b1, 32'h0, 32'h0BADF00D, 32'h0BADF00D, 1'b0, "t3pre");
`ifdef DMEM_ERR_EN
      txn(1'b1, 32'h400, 32'hA5A5A5A5, 32'h0, 1'b1, "t3w");
      txn(1'b0, 32'h0, 32'h0, 32'h0BADF00D, 1'b0, "t3r");
      txn(1'b0, 32'h13, 32'h0, 32'h0, 1'b1, "t4e");
      txn(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "t4ok");
`else
      txn(1'b1, 32'h400, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, "t3w");
      txn(1'b0, 32'h0, 32'h0, 32'hA5A5A5A5, 1'b0, "t3r");
      txn(1'b0, 32'h13, 32'h0, 32'hDEADBEEF, 1'b0, "t4lo");
`endif

      // Reset during WAIT drops the write.
      txn(1'b1, 32'h20, 32'h11110000, 32'h11110000, 1'b0, "t5pre");
      bus.req_in = 1'b1; bus.writeCntrl_in = 1'b1;
      bus.address_in = 32'h20; bus.writeData_in = 32'h12345678;
      @(negedge clk);
      bus.req_in = 1'b0;
      reset = 1'b1;
      chk("t5.rdyT1", 32'(bus.ready_out), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      chk("t5.rdy", 32'(bus.ready_out), 32'd1);
      chk("t5.ack", 32'(bus.ack_out), 32'd0);
      chk("t5.data", bus.data_out, 32'd0);
      @(negedge clk);
      chk("t5.ack2", 32'(bus.ack_out), 32'd0);
      @(negedge clk);
      chk("t5.ack3", 32'(bus.ack_out), 32'd0);
      txn(1'b0, 32'h20, 32'h0, 32'h11110000, 1'b0, "t5r");

      // Held request: accepts every 4 cycles, ack 3 cycles after each.
      bus.req_in = 1'b1; bus.writeCntrl_in = 1'b0;
      bus.address_in = 32'h10; bus.writeData_in = 32'h0;
      for (int k = 0; k < 12; k++) begin
         chk($sformatf("t6.rdy%0d", k), 32'(bus.ready_out), 32'((k % 4) == 0));
         chk($sformatf("t6.ack%0d", k), 32'(bus.ack_out), 32'((k % 4) == 3));
         if ((k % 4) == 3) chk($sformatf("t6.data%0d", k), bus.data_out, 32'hDEADBEEF);
         @(negedge clk);
      end
      bus.req_in = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
